// File: rtl/rv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Pure declarations: no logic, no latency, no flow control.
package rv_fetch_pkg;
    localparam int          XLEN_PC   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {RESET, FETCH, FLUSH} fetch_state_e;

    typedef struct packed {
        logic [XLEN_PC-1:0] pc;
        logic [31:0]        instr;
    } fq_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// QDEPTH-entry FIFO of {pc, instr}; head is read combinationally, a push is visible next cycle.
// No internal backpressure: the producer's credit check keeps pushes within capacity; flush beats push.
module fetch_queue
    import rv_fetch_pkg::*;
#(
    parameter int QDEPTH = 2
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  fq_entry_t                    i_push_dat,
    input  logic                         i_pop,
    input  logic                         i_flush,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(QDEPTH+1)-1:0]  o_count,
    output fq_entry_t                    o_head
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH+1);

    fq_entry_t         r_mem [QDEPTH];
    logic [AW-1:0]     r_rd_ptr;
    logic [AW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push & ~i_flush;
    assign w_pop   = i_pop & ~i_flush & ~o_empty;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(QDEPTH));
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
    end
endmodule

// File: rtl/if_fetch.sv
// Fetch stage: owns the PC, issues in-order imem requests, queues returned words for IF/ID.
// Grant-to-valid 2 cycles at best; i_stall holds the head and requests stop once credit runs out.
module if_fetch
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic [31:0] o_instr
);
    localparam int CW = $clog2(QDEPTH+1);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] w_out_nxt;
    logic [CW-1:0] w_drop_nxt;
    logic [CW-1:0] w_occ;
    logic [CW:0]   w_credit_used;
    logic [31:0]   w_redirect_pc;
    logic          w_grant;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    fq_entry_t     w_head;

    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
    assign w_grant       = o_imem_req & i_imem_gnt;
    assign w_pop         = o_valid & ~i_stall & ~i_redirect;
    assign w_push        = i_imem_rvalid & ~i_redirect & (r_drop_cnt == '0);

    // An entry popped this cycle frees its slot at once, which is what sustains one fetch per cycle.
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_occ} - (CW+1)'(w_pop);
    assign o_imem_req    = ~rst & ~i_redirect & (w_credit_used < (CW+1)'(QDEPTH));
    assign o_imem_addr   = r_fetch_pc;

    // r_outstanding counts every request in flight, dropped ones included, so on a redirect
    // all of it becomes drop debt (the earlier debt plus the still-live requests).
    always_comb begin
        w_out_nxt  = r_outstanding + CW'(w_grant) - CW'(i_imem_rvalid);
        w_drop_nxt = r_drop_cnt;
        if (i_redirect)
            w_drop_nxt = r_outstanding - CW'(i_imem_rvalid);
        else if (i_imem_rvalid && r_drop_cnt != '0)
            w_drop_nxt = r_drop_cnt - CW'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RESET:   w_state_nxt = FETCH;
            FETCH:   if (i_redirect && w_drop_nxt != '0) w_state_nxt = FLUSH;
            FLUSH:   if (w_drop_nxt == '0) w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RESET;
        else     r_state <= w_state_nxt;
    end

    // Kept responses are always sequential from the last redirect/reset target,
    // so their pc is simply counted rather than carried alongside each request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_drop_cnt    <= w_drop_nxt;
            if (i_redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
            end else begin
                if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push)  r_rsp_pc   <= r_rsp_pc + 32'd4;
            end
        end
    end

    fetch_queue #(.QDEPTH(QDEPTH)) u_fetch_queue (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat ('{pc: r_rsp_pc, instr: i_imem_rdata}),
        .i_pop      (w_pop),
        .i_flush    (i_redirect),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_occ),
        .o_head     (w_head)
    );

    assign o_valid = ~w_empty;
    assign o_pc    = o_valid ? w_head.pc    : r_fetch_pc;
    assign o_instr = o_valid ? w_head.instr : NOP_INSTR;
    assign o_pc4   = o_pc + 32'd4;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_full && !w_pop));
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (rst)
        i_imem_rvalid |-> (r_outstanding != '0));
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: fixed-latency in-order memory model plus a consumed-pc scoreboard.
module tb_if_fetch;
    import rv_fetch_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        i_stall;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_pc4;
    logic [31:0] o_instr;

    if_fetch #(.RESET_PC(TB_RESET_PC), .QDEPTH(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_pc4         (o_pc4),
        .o_instr       (o_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          lat    = 1;
    logic [31:0] exp_pc;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             n_pass++;
    endtask

    // One clock: score any consume, log any grant, then present this cycle's memory response.
    task automatic tick();
        logic rst_at_edge;
        #1;
        if (!rst && o_valid && !i_stall && !i_redirect) begin
            chk_eq("cons_pc",    o_pc,    exp_pc);
            chk_eq("cons_instr", o_instr, mem_word(exp_pc));
            chk_eq("cons_pc4",   o_pc4,   exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
        end
        if (!rst && o_imem_req && i_imem_gnt) begin
            pend_addr.push_back(o_imem_addr);
            pend_due.push_back(cyc + lat);
        end
        rst_at_edge = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_at_edge) begin
            pend_addr.delete();
            pend_due.delete();
        end
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            i_imem_rvalid = 1'b0;
            i_imem_rdata  = '0;
        end
    endtask

    task automatic run_until_valid(input int budget, input string tag);
        int n = 0;
        #1;
        while (!o_valid && n < budget) begin
            tick();
            #1;
            n++;
        end
        chk_eq(tag, {31'b0, o_valid}, 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target, input string tag);
        i_redirect    = 1'b1;
        i_redirect_pc = target;
        #1;
        chk_eq(tag, {31'b0, o_imem_req}, 32'd0);
        tick();
        i_redirect = 1'b0;
        exp_pc     = {target[31:2], 2'b00};
    endtask

    initial begin
        logic found;
        rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        i_imem_gnt = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        exp_pc = TB_RESET_PC;

        // Reset values
        tick(); tick(); tick();
        #1;
        chk_eq("rst_req",   {31'b0, o_imem_req}, 32'd0);
        chk_eq("rst_addr",  o_imem_addr, 32'h100);
        chk_eq("rst_valid", {31'b0, o_valid}, 32'd0);
        chk_eq("rst_pc",    o_pc,    32'h100);
        chk_eq("rst_pc4",   o_pc4,   32'h104);
        chk_eq("rst_instr", o_instr, NOP_INSTR);

        // First request right after release, valid two cycles after the grant, then 1/cycle
        rst = 1'b0;
        #1;
        chk_eq("first_req",  {31'b0, o_imem_req}, 32'd1);
        chk_eq("first_addr", o_imem_addr, 32'h100);
        tick(); #1;
        chk_eq("c1_valid", {31'b0, o_valid}, 32'd0);
        chk_eq("c1_addr",  o_imem_addr, 32'h104);
        tick(); #1;
        chk_eq("c2_valid", {31'b0, o_valid}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_eq("stream_valid", {31'b0, o_valid}, 32'd1);
            tick();
        end

        // Stall: head holds, queue fills, requests stop; release resumes without gap
        i_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_eq("stall_valid", {31'b0, o_valid}, 32'd1);
            chk_eq("stall_pc",    o_pc, exp_pc);
            chk_eq("stall_req",   {31'b0, o_imem_req}, 32'd0);
            tick();
        end
        i_stall = 1'b0;
        #1;
        chk_eq("release_req", {31'b0, o_imem_req}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            #1;
            chk_eq("resume_valid", {31'b0, o_valid}, 32'd1);
            tick();
        end

        // Redirect with two responses in flight at latency 3
        rst = 1'b1; lat = 3;
        tick(); tick();
        rst = 1'b0; exp_pc = TB_RESET_PC;
        tick(); tick(); #1;
        chk_eq("out2_req", {31'b0, o_imem_req}, 32'd0);
        do_redirect(32'h0000_2000, "redir_req");
        #1;
        chk_eq("drain_req", {31'b0, o_imem_req}, 32'd0);
        tick(); #1;
        chk_eq("newpath_req",  {31'b0, o_imem_req}, 32'd1);
        chk_eq("newpath_addr", o_imem_addr, 32'h2000);
        run_until_valid(20, "redir_valid0"); tick();
        run_until_valid(20, "redir_valid1"); tick();

        // Redirect in the same cycle as an rvalid while another old-path grant is in flight
        lat = 2; found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #1;
            if (i_imem_rvalid && pend_addr.size() >= 1) found = 1'b1;
            else tick();
        end
        chk_eq("coll_found", {31'b0, found}, 32'd1);
        do_redirect(32'h0000_3000, "coll_req");
        run_until_valid(20, "coll_valid0"); tick();
        run_until_valid(20, "coll_valid1"); tick();

        // Misaligned redirect target is word-aligned
        lat = 1;
        for (int i = 0; i < 4; i++) tick();
        do_redirect(32'h0000_0103, "mis_req");
        #1;
        chk_eq("mis_addr", o_imem_addr, 32'h100);
        run_until_valid(20, "mis_valid0"); tick();
        run_until_valid(20, "mis_valid1"); tick();

        // PC wrap at the top of the address space
        do_redirect(32'hFFFF_FFFC, "wrap_req");
        #1;
        chk_eq("wrap_addr0", o_imem_addr, 32'hFFFF_FFFC);
        for (int i = 0; i < 10 && !o_imem_req; i++) begin
            tick(); #1;
        end
        tick(); #1;
        chk_eq("wrap_addr1", o_imem_addr, 32'h0000_0000);
        run_until_valid(20, "wrap_valid0");
        chk_eq("wrap_pc",  o_pc,  32'hFFFF_FFFC);
        chk_eq("wrap_pc4", o_pc4, 32'h0000_0000);
        tick();
        run_until_valid(20, "wrap_valid1"); tick();

        // Reset with a full queue: everything forgotten, fetch restarts at RESET_PC
        i_stall = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk_eq("full_valid", {31'b0, o_valid}, 32'd1);
        chk_eq("full_req",   {31'b0, o_imem_req}, 32'd0);
        rst = 1'b1;
        tick(); #1;
        chk_eq("midrst_valid", {31'b0, o_valid}, 32'd0);
        chk_eq("midrst_instr", o_instr, NOP_INSTR);
        chk_eq("midrst_req",   {31'b0, o_imem_req}, 32'd0);
        rst = 1'b0; i_stall = 1'b0; exp_pc = TB_RESET_PC;
        #1;
        chk_eq("restart_req",  {31'b0, o_imem_req}, 32'd1);
        chk_eq("restart_addr", o_imem_addr, TB_RESET_PC);
        run_until_valid(20, "restart_valid0"); tick();
        run_until_valid(20, "restart_valid1"); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
